// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the default parameters, the word width, the FSM state encoding
// and the layout of an instruction buffer entry.
package fetch_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int unsigned DEPTH_DEF = 2;

    // Width of the stale-response counter; repeated redirects can stack
    // several generations of abandoned requests in the memory pipeline.
    localparam int unsigned STALE_W = 16;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } buf_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for both the fetch address tag queue and the
// instruction buffer.
// Ports: clk/reset (sync, active-high), flush (empties the FIFO, wins over
// push/pop), push/push_data, pop, head_data (oldest entry), count (entries).
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // Pointer increment with wrap for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop_ok    = pop & ~flush & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok   = push & ~flush & (~full | pop_ok);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Control state; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to instruction
// memory, tags each request with its address, buffers returned words and
// presents them in order to decode. Redirects flush the buffer and cause
// responses for requests already in flight to be discarded.
// Ports: clk, reset (sync, active-high); imem_req_valid/ready + imem_addr
// (request channel); imem_rsp_valid + imem_rsp_data (in-order responses);
// redirect + redirect_pc; instr_valid/ready + instr/instr_pc (to decode).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int unsigned       DEPTH        = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e       state_q, state_d;
    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [STALE_W-1:0] stale_q, stale_d;

    logic [CNT_W-1:0]   tag_count;
    logic [CNT_W-1:0]   buf_count;
    logic [WORD_W-1:0]  tag_head;
    buf_entry_t         buf_head;
    buf_entry_t         buf_push;
    logic [CNT_W:0]     occupancy;

    logic req_fire;
    logic instr_fire;
    logic drop_rsp;
    logic rsp_stale;
    logic rsp_live;

    // Live requests in flight plus buffered words; each live request owns a buffer slot.
    assign occupancy      = (CNT_W+1)'(tag_count) + (CNT_W+1)'(buf_count);
    assign imem_req_valid = ~reset & (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign instr_valid    = ~reset & (buf_count != '0);
    assign instr_fire     = instr_valid & instr_ready;
    assign instr          = instr_valid ? buf_head.instr : '0;
    assign instr_pc       = instr_valid ? buf_head.pc    : '0;

    // Stale requests are always older than live ones, so they answer first.
    assign rsp_stale      = imem_rsp_valid & drop_rsp;
    assign rsp_live       = imem_rsp_valid & ~drop_rsp & (tag_count != '0);

    assign buf_push.instr = imem_rsp_data;
    assign buf_push.pc    = tag_head;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_live),
        .head_data (tag_head),
        .count     (tag_count)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(buf_entry_t))
    ) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (rsp_live),
        .push_data (buf_push),
        .pop       (instr_fire),
        .head_data (buf_head),
        .count     (buf_count)
    );

    // Fetch PC: redirect target (word aligned) wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~WORD_W'(3);
        end else if (req_fire) begin
            pc_d = pc_q + WORD_W'(4);
        end
    end

    // On redirect every request still owed a response, including one issued
    // this cycle, becomes stale; a live response this cycle is discarded.
    always_comb begin
        stale_d = stale_q;
        if (rsp_stale) begin
            stale_d = stale_d - STALE_W'(1);
        end
        if (redirect) begin
            stale_d = stale_d + STALE_W'(tag_count) - STALE_W'(rsp_live) + STALE_W'(req_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            stale_q <= '0;
        end else begin
            pc_q    <= pc_d;
            stale_q <= stale_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: FLUSH while stale responses are still owed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stale_d != '0) state_d = ST_FLUSH;
            ST_FLUSH: if (stale_d == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        drop_rsp = 1'b0;
        case (state_q)
            ST_FLUSH: drop_rsp = 1'b1;
            default:  drop_rsp = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order instruction memory model with
// programmable latency, a decode-stream reference model and directed phases.
module tb_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_ent_t;

    int          checks    = 0;
    int          failures  = 0;
    int unsigned cyc       = 0;
    int unsigned last_due  = 0;
    int unsigned lat_lo    = 1;
    int unsigned lat_hi    = 1;
    int          delivered = 0;
    mem_ent_t    mem_q[$];
    logic [31:0] fired_q[$];
    logic [31:0] exp_pc    = RV;
    logic [31:0] exp_fetch = RV;
    logic [31:0] prev_addr = '0;
    logic        prev_stall = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Memory: presents the oldest due response shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Reference model and per-cycle comparison; also accepts memory requests.
    always @(negedge clk) begin : monitor
        int unsigned due;
        logic        fire;
        if (reset) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_instr_pc", instr_pc, 32'd0);
            exp_pc     = RV;
            exp_fetch  = RV;
            prev_stall = 1'b0;
            last_due   = 0;
            mem_q.delete();
        end else begin
            if (imem_req_valid) chk("fetch_addr", imem_addr, exp_fetch);
            if (prev_stall) begin
                chk("stall_valid", 32'(imem_req_valid), 32'd1);
                chk("stall_addr", imem_addr, prev_addr);
            end
            if (instr_valid) begin
                chk("instr_pc", instr_pc, exp_pc);
                chk("instr_data", instr, mem_word(instr_pc));
            end
            if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
            fire = imem_req_valid && imem_req_ready;
            if (fire) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: imem_addr, due: due});
                fired_q.push_back(imem_addr);
            end
            prev_stall = imem_req_valid && !imem_req_ready && !redirect;
            prev_addr  = imem_addr;
            if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect) begin
                exp_pc    = redirect_pc & ~32'd3;
                exp_fetch = redirect_pc & ~32'd3;
            end else if (fire) begin
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    end

    task automatic wait_valid(input string name, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) chk(name, instr_pc, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0;
        bit found;
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // First fetch right after release, first word two cycles later.
        @(negedge clk);
        chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rel_addr0", imem_addr, 32'h0);
        chk("rel_ivalid_c0", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("rel_addr1", imem_addr, 32'h4);
        chk("rel_ivalid_c1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("rel_ivalid_c2", 32'(instr_valid), 32'd1);
        chk("rel_first_pc", instr_pc, 32'h0);

        @(posedge clk); #2;
        d0 = delivered;
        repeat (20) @(posedge clk);
        #2 chk("stream_progress", 32'(delivered - d0 >= 10), 32'd1);

        // Decode back-pressure: buffer fills to two, fetch stops.
        instr_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_ivalid", 32'(instr_valid), 32'd1);
        chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #2 instr_ready = 1'b1;
        @(negedge clk); chk("drain_v0", 32'(instr_valid), 32'd1);
        @(negedge clk); chk("drain_v1", 32'(instr_valid), 32'd1);
        @(negedge clk); chk("drain_v2", 32'(instr_valid), 32'd0);

        // Redirect with two requests in flight.
        @(posedge clk); #2;
        lat_lo = 4; lat_hi = 4;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #2;
            if (mem_q.size() == 2) found = 1'b1;
        end
        chk("r023_setup", 32'(found), 32'd1);
        if (found) begin
            redirect = 1'b1; redirect_pc = 32'h0000_0100;
            @(posedge clk); #2 redirect = 1'b0;
            @(negedge clk);
            chk("r023_empty", 32'(instr_valid), 32'd0);
            chk("r023_req_valid", 32'(imem_req_valid), 32'd1);
            chk("r023_addr", imem_addr, 32'h0000_0100);
            wait_valid("r023_first_pc", 32'h0000_0100);
        end

        // Redirect coinciding with a response and a decode transfer.
        @(posedge clk); #2;
        lat_lo = 1; lat_hi = 1;
        repeat (15) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (instr_valid && imem_rsp_valid) found = 1'b1;
        end
        chk("r024_setup", 32'(found), 32'd1);
        if (found) begin
            d0 = delivered;
            redirect = 1'b1; redirect_pc = 32'h0000_0200;
            @(posedge clk); #2 redirect = 1'b0;
            chk("r024_taken", 32'(delivered - d0), 32'd1);
            @(negedge clk);
            chk("r024_empty", 32'(instr_valid), 32'd0);
            wait_valid("r024_first_pc", 32'h0000_0200);
        end

        // Address wrap at the top of memory; low target bits ignored.
        @(posedge clk); #2;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
        @(posedge clk); #2;
        redirect = 1'b0;
        fired_q.delete();
        @(negedge clk);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        repeat (10) @(posedge clk);
        #2 chk("wrap_count", 32'(fired_q.size() >= 3), 32'd1);
        if (fired_q.size() >= 3) begin
            chk("wrap_a0", fired_q[0], 32'hFFFF_FFF8);
            chk("wrap_a1", fired_q[1], 32'hFFFF_FFFC);
            chk("wrap_a2", fired_q[2], 32'h0000_0000);
        end

        // Random request stalls, decode stalls and 1-4 cycle latency.
        lat_lo = 1; lat_hi = 4;
        d0 = delivered;
        for (int i = 0; i < 300; i++) begin
            imem_req_ready = 1'($urandom_range(1, 0));
            instr_ready    = ($urandom_range(3, 0) != 0);
            redirect       = (i == 150);
            redirect_pc    = 32'h0000_1000;
            @(posedge clk); #2;
        end
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        chk("rand_progress", 32'(delivered - d0 >= 30), 32'd1);

        // Reset with requests in flight; old responses must not surface.
        lat_lo = 3; lat_hi = 3;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        lat_lo = 1; lat_hi = 1;
        wait_valid("rst2_first_pc", 32'h0);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the instruction buffer entry count and the cap on requests in flight plus buffered words.
REQ-003 The block SHALL provide these ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request offered
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  read data returned, in request order, at most one per cycle
- imem_rsp_data  in  32  instruction word
- redirect  in  1  taken branch or PC write, from PCS qualified by condition logic
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0
- instr_valid  out  1  buffered instruction presented to decode
- instr_ready  in  1  decode consumes the presented instruction
- instr  out  32  instruction word (Op = [27:26], Funct = [25:20], Rd = [15:12])
- instr_pc  out  32  fetch address of instr

Function
REQ-004 A request SHALL transfer when imem_req_valid and imem_req_ready are both high on one edge; an instruction SHALL transfer when instr_valid and instr_ready are both high.
REQ-005 imem_req_valid SHALL be high iff not in reset and (outstanding + buffer count) < DEPTH, where outstanding counts accepted requests not yet answered and not marked stale.
REQ-006 imem_req_valid and imem_addr SHALL remain stable while imem_req_ready is low, except when redirect is high.
REQ-007 The fetch PC SHALL advance by 4 on each request transfer, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-008 Each accepted request SHALL push its address into an address tag queue; each non-stale response SHALL pop that queue and write {data, address} into the buffer.
REQ-009 The buffer SHALL be FIFO; instr and instr_pc SHALL come from the head entry; instr_valid SHALL equal buffer non-empty; a push and a pop in one cycle SHALL leave the count unchanged.
REQ-010 The buffer SHALL never overflow, because REQ-005 reserves a slot for every outstanding request; a response arriving with no outstanding request SHALL be ignored.
REQ-011 On redirect, the block SHALL clear the buffer next cycle, set the fetch PC to redirect_pc, and mark every outstanding request as stale, including a request transferring that same cycle.
REQ-012 A response returned for a stale request SHALL be dropped (stale count decrements by 1, no buffer write), including a response arriving in the redirect cycle itself.
REQ-013 The first request after a redirect SHALL be issued no earlier than the cycle after redirect and SHALL carry redirect_pc.
REQ-014 When an instruction transfer and a redirect occur together, decode SHALL retain the transferred instruction and the buffer SHALL still be cleared.
REQ-015 Latency: with imem_req_ready held high and 1-cycle response, the first instr_valid after reset or redirect SHALL occur 2 cycles later; steady-state throughput SHALL be 1 instruction/cycle when instr_ready is held high.
REQ-016 The FSM SHALL have states RUN (normal operation) and FLUSH (stale count > 0); FLUSH SHALL return to RUN when the stale count reaches 0, and requests are allowed in both states.

Reset
REQ-017 While reset is high, the block SHALL force fetch PC = RESET_VECTOR, buffer empty, outstanding = 0, stale = 0, state = RUN, imem_req_valid = 0, instr_valid = 0, and instr/instr_pc = 0.
REQ-018 Any response arriving during or after reset for a pre-reset request SHALL be ignored; the memory is reset with the same reset.

Structure
REQ-019 Package fetch_pkg SHALL hold RESET_VECTOR default, DEPTH default, the width constant WORD_W = 32, the FSM state enumeration, and the buffer entry type {instr, pc}.
REQ-020 The buffer SHALL be a sub-module fetch_fifo (parameterised depth/width, push/pop/flush, count output), instantiated for both the address tag queue and the instruction buffer.

Verification
REQ-021 Reset then always-ready memory with 1-cycle latency -> imem_addr 0, 4, 8, ...; instr_pc 0, 4, 8 in order; first instr_valid 2 cycles after reset release.
REQ-022 instr_ready low for 5 cycles -> exactly 2 words buffered, imem_req_valid low, no data lost or reordered after instr_ready rises.
REQ-023 Redirect to 32'h0000_0100 with 2 requests outstanding -> both responses dropped, buffer empty, next imem_addr 32'h100, next instr_pc 32'h100.
REQ-024 Redirect in the same cycle as a response and an instruction transfer -> transferred word accepted by decode, response dropped, buffer empty.
REQ-025 imem_req_ready toggles randomly and response latency varies 1-4 cycles -> imem_addr stable while stalled, instr stream identical to the memory image in address order.
REQ-026 Fetch PC at 32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
